mem_stage_wb: RTL and testbench

//  Consumer end of the EX/MEM pipeline register: MEM stage plus MEM/WB pipeline register.

---
 rtl/mem_stage_wb_pkg.sv | 41 ++++
 rtl/mem_stage_wb_if.sv | 23 ++
 rtl/mem_periph_timer.sv | 61 ++++++
 rtl/mem_stage_wb.sv | 118 +++++++++++
 tb/tb_mem_stage_wb.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_wb_pkg.sv
// Shared definitions for the MEM stage: write-back select codes, peripheral map, timer control bits.
// Pure constants and one combinational helper; no state.
// No flow control; consumers use these constants directly.
package mem_stage_wb_pkg;

  // Write-back source select carried down the pipe as MemtoReg
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_PC4  = 2'b10,
    WB_ZERO = 2'b11
  } wb_sel_e;

  // Peripheral register byte addresses (upper nibble doubles as the region select)
  localparam logic [31:0] ADDR_TH   = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL   = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED  = 32'h4000_000C;

  // Timer control register bit positions
  localparam int TCON_RUN = 0;
  localparam int TCON_IE  = 1;
  localparam int TCON_IS  = 2;

  // Write-back source mux, shared by the forwarding path and the MEM/WB register
  function automatic logic [31:0] wb_mux(input logic [1:0]  sel,
                                         input logic [31:0] alu,
                                         input logic [31:0] mem,
                                         input logic [31:0] pc4);
    logic [31:0] res;
    res = 32'h0;
    case (sel)
      WB_ALU:  res = alu;
      WB_MEM:  res = mem;
      WB_PC4:  res = pc4;
      default: res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_stage_wb_if.sv
// EX/MEM pipeline register fields presented to the MEM stage.
// No latency; plain bundle of wires.
// No backpressure: the pipeline never stalls this stage.
interface mem_stage_wb_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] WriteData;
  logic [4:0]  WriteAddr;
  logic [1:0]  MemtoReg;
  logic        RegWrite;
  logic [31:0] ALU_out;
  logic [31:0] PC_Plus_4;

  // EX/MEM register side drives the fields
  modport master (
    output MemRead, MemWrite, WriteData, WriteAddr, MemtoReg, RegWrite, ALU_out, PC_Plus_4
  );

  // MEM stage consumes them
  modport slave (
    input  MemRead, MemWrite, WriteData, WriteAddr, MemtoReg, RegWrite, ALU_out, PC_Plus_4
  );
endinterface

// File: rtl/mem_periph_timer.sv
// Reloading 32-bit timer (TH reload, TL count, TCON run/irq-enable/irq-status) with irq output.
// Register reads are combinational from the flops; bus writes take effect at the next posedge.
// No backpressure; only built when MEM_TIMER_EN is defined, otherwise this file is empty.
`ifdef MEM_TIMER_EN
module mem_periph_timer
  import mem_stage_wb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_th_i,
  input  logic        wr_tl_i,
  input  logic        wr_tcon_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] th_o,
  output logic [31:0] tl_o,
  output logic [2:0]  tcon_o,
  output logic        irq_o
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        wrap;

  // Next-state: a bus write always beats the counting/reload update in the same cycle
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    wrap   = tcon_q[TCON_RUN] && (tl_q == 32'hFFFF_FFFF);

    if (wr_th_i) th_d = wdata_i;

    if (wr_tl_i)                tl_d = wdata_i;
    else if (wrap)              tl_d = th_q;
    else if (tcon_q[TCON_RUN])  tl_d = tl_q + 32'd1;

    if (wr_tcon_i)                        tcon_d = wdata_i[2:0];
    else if (wrap && tcon_q[TCON_IE])     tcon_d[TCON_IS] = 1'b1;
  end

  // Timer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q   <= 32'h0;
      tl_q   <= 32'h0;
      tcon_q <= 3'h0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign tcon_o = tcon_q;
  assign irq_o  = tcon_q[TCON_IE] & tcon_q[TCON_IS];

endmodule
`endif

// File: rtl/mem_stage_wb.sv
// MEM stage (data RAM, LED/timer peripherals) plus MEM/WB pipeline register; timer built only with MEM_TIMER_EN.
// Latency: 1 cycle to MEM/WB outputs; o_fwd_data is combinational. RAM read is combinational (old data on RAW).
// No backpressure: no stall and no flush; every cycle's EX/MEM fields are consumed.
module mem_stage_wb
  import mem_stage_wb_pkg::*;
#(
  parameter int          RAM_AW        = 8,
  parameter logic [3:0]  PERIPH_NIBBLE = 4'h4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_stage_wb_if.slave        exmem,
  output logic                 o_RegWrite,
  output logic [4:0]           o_WriteAddr,
  output logic [31:0]          o_WriteData,
  output logic [31:0]          o_fwd_data,
  output logic [7:0]           o_leds,
  output logic                 o_irq
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  logic [31:0]       ram_q [0:RAM_DEPTH-1];
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       ram_rdata;
  logic              periph_sel;
  logic [25:0]       word_off;
  logic              ram_we;
  logic              led_we;
  logic [31:0]       periph_rdata;
  logic [31:0]       load_data;
  logic [31:0]       th_val;
  logic [31:0]       tl_val;
  logic [2:0]        tcon_val;
  logic [7:0]        leds_q;
  logic              regwrite_q, regwrite_d;
  logic [4:0]        waddr_q;
  logic [31:0]       wdata_q;
  logic              unused_addr_lsbs;

  // Byte offset bits never take part in decode
  assign unused_addr_lsbs = ^exmem.ALU_out[1:0];

  assign periph_sel = (exmem.ALU_out[31:28] == PERIPH_NIBBLE);
  assign word_off   = exmem.ALU_out[27:2];
  // Upper RAM address bits are dropped, so addresses alias modulo the RAM size
  assign ram_idx    = exmem.ALU_out[RAM_AW+1:2];
  assign ram_rdata  = ram_q[ram_idx];
  assign ram_we     = exmem.MemWrite & ~periph_sel;
  assign led_we     = exmem.MemWrite & periph_sel & (word_off == ADDR_LED[27:2]);

  // Peripheral read mux; unmapped offsets read as zero
  always_comb begin
    periph_rdata = 32'h0;
    if (word_off == ADDR_TH[27:2])        periph_rdata = th_val;
    else if (word_off == ADDR_TL[27:2])   periph_rdata = tl_val;
    else if (word_off == ADDR_TCON[27:2]) periph_rdata = {29'h0, tcon_val};
    else if (word_off == ADDR_LED[27:2])  periph_rdata = {24'h0, leds_q};
  end

  assign load_data  = exmem.MemRead ? (periph_sel ? periph_rdata : ram_rdata) : 32'h0;
  assign o_fwd_data = wb_mux(exmem.MemtoReg, exmem.ALU_out, load_data, exmem.PC_Plus_4);
  assign regwrite_d = exmem.RegWrite & (exmem.WriteAddr != 5'd0);

`ifdef MEM_TIMER_EN
  logic wr_th, wr_tl, wr_tcon;
  assign wr_th   = exmem.MemWrite & periph_sel & (word_off == ADDR_TH[27:2]);
  assign wr_tl   = exmem.MemWrite & periph_sel & (word_off == ADDR_TL[27:2]);
  assign wr_tcon = exmem.MemWrite & periph_sel & (word_off == ADDR_TCON[27:2]);

  mem_periph_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .wr_th_i   (wr_th),
    .wr_tl_i   (wr_tl),
    .wr_tcon_i (wr_tcon),
    .wdata_i   (exmem.WriteData),
    .th_o      (th_val),
    .tl_o      (tl_val),
    .tcon_o    (tcon_val),
    .irq_o     (o_irq)
  );
`else
  assign th_val   = 32'h0;
  assign tl_val   = 32'h0;
  assign tcon_val = 3'h0;
  assign o_irq    = 1'b0;
`endif

  // Data RAM write; contents survive reset, but a store coinciding with reset is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
    end else if (ram_we) begin
      ram_q[ram_idx] <= exmem.WriteData;
    end
  end

  // LED register and MEM/WB pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_q     <= 8'h0;
      regwrite_q <= 1'b0;
      waddr_q    <= 5'd0;
      wdata_q    <= 32'h0;
    end else begin
      if (led_we) leds_q <= exmem.WriteData[7:0];
      regwrite_q <= regwrite_d;
      waddr_q    <= exmem.WriteAddr;
      wdata_q    <= o_fwd_data;
    end
  end

  assign o_RegWrite  = regwrite_q;
  assign o_WriteAddr = waddr_q;
  assign o_WriteData = wdata_q;
  assign o_leds      = leds_q;

endmodule

// File: tb/tb_mem_stage_wb.sv
// Directed bench for mem_stage_wb: RAM, write-back mux, $0 suppression, LED/peripheral decode, reset, timer.
// Inputs driven 1 time unit after posedge; outputs sampled at that same point (away from the edge).
// Timer checks compile in only with MEM_TIMER_EN; otherwise the disabled-timer behaviour is checked.
module tb_mem_stage_wb;
  import mem_stage_wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        o_RegWrite;
  logic [4:0]  o_WriteAddr;
  logic [31:0] o_WriteData;
  logic [31:0] o_fwd_data;
  logic [7:0]  o_leds;
  logic        o_irq;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mem_stage_wb_if exmem ();

  mem_stage_wb dut (
    .clk         (clk),
    .reset       (reset),
    .exmem       (exmem.slave),
    .o_RegWrite  (o_RegWrite),
    .o_WriteAddr (o_WriteAddr),
    .o_WriteData (o_WriteData),
    .o_fwd_data  (o_fwd_data),
    .o_leds      (o_leds),
    .o_irq       (o_irq)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] wdata,
                       input logic [4:0] wa, input logic [1:0] m2r, input logic rw,
                       input logic [31:0] alu, input logic [31:0] pc4);
    exmem.MemRead   = rd;
    exmem.MemWrite  = wr;
    exmem.WriteData = wdata;
    exmem.WriteAddr = wa;
    exmem.MemtoReg  = m2r;
    exmem.RegWrite  = rw;
    exmem.ALU_out   = alu;
    exmem.PC_Plus_4 = pc4;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 32'h0, 5'd0, 2'b00, 0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_regwrite", o_RegWrite, 0);
    check_val("rst_waddr",    o_WriteAddr, 0);
    check_val("rst_wdata",    o_WriteData, 0);
    check_val("rst_leds",     o_leds, 0);
    check_val("rst_irq",      o_irq, 0);
    reset = 1'b0;
    step();
    check_val("idle_wdata",   o_WriteData, 0);
    check_val("idle_regwrite", o_RegWrite, 0);

    // store then load the same word
    drive(0, 1, 32'hDEAD_BEEF, 5'd0, 2'b00, 0, 32'h10, 32'h0);
    step();
    check_val("sw_regwrite", o_RegWrite, 0);
    drive(1, 0, 32'h0, 5'd8, 2'b01, 1, 32'h10, 32'h0);
    #1;
    check_val("lw_fwd", o_fwd_data, 32'hDEAD_BEEF);
    step();
    check_val("lw_wdata",    o_WriteData, 32'hDEAD_BEEF);
    check_val("lw_waddr",    o_WriteAddr, 8);
    check_val("lw_regwrite", o_RegWrite, 1);

    // writes to $0 are suppressed
    drive(0, 0, 32'h0, 5'd0, 2'b00, 1, 32'h5, 32'h0);
    step();
    check_val("r0_regwrite", o_RegWrite, 0);
    check_val("r0_wdata",    o_WriteData, 5);

    // PC+4 and zero select
    drive(0, 0, 32'h0, 5'd31, 2'b10, 1, 32'h123, 32'h0040_0008);
    step();
    check_val("pc4_wdata", o_WriteData, 32'h0040_0008);
    check_val("pc4_waddr", o_WriteAddr, 31);
    drive(0, 0, 32'h0, 5'd31, 2'b11, 1, 32'h123, 32'h0040_0008);
    step();
    check_val("zero_wdata", o_WriteData, 0);

    // LED register and peripheral reads
    drive(0, 1, 32'h1A5, 5'd0, 2'b00, 0, 32'h4000_000C, 32'h0);
    step();
    check_val("led_val", o_leds, 8'hA5);
    drive(1, 0, 32'h0, 5'd4, 2'b01, 1, 32'h4000_000C, 32'h0);
    step();
    check_val("led_read", o_WriteData, 32'h0000_00A5);
    drive(1, 0, 32'h0, 5'd4, 2'b01, 1, 32'h4000_0020, 32'h0);
    step();
    check_val("unmapped_read", o_WriteData, 0);
    drive(0, 1, 32'h77, 5'd0, 2'b00, 0, 32'h4000_0020, 32'h0);
    step();
    check_val("unmapped_write_leds", o_leds, 8'hA5);

    // load data is zero when MemRead is low
    drive(0, 0, 32'h0, 5'd4, 2'b01, 1, 32'h10, 32'h0);
    step();
    check_val("noread_wdata", o_WriteData, 0);

    // simultaneous read+write returns the old word; new word visible next cycle, also via alias
    drive(1, 1, 32'h1234_5678, 5'd5, 2'b01, 1, 32'h10, 32'h0);
    step();
    check_val("rw_old", o_WriteData, 32'hDEAD_BEEF);
    drive(1, 0, 32'h0, 5'd5, 2'b01, 1, 32'h10, 32'h0);
    step();
    check_val("rw_new", o_WriteData, 32'h1234_5678);
    drive(1, 0, 32'h0, 5'd5, 2'b01, 1, 32'h8000_0412, 32'h0);
    step();
    check_val("alias_read", o_WriteData, 32'h1234_5678);

    // reset mid-operation drops a pending store and clears state immediately
    drive(0, 1, 32'h1111_1111, 5'd0, 2'b00, 0, 32'h20, 32'h0);
    step();
    drive(0, 0, 32'h0, 5'd9, 2'b00, 1, 32'h99, 32'h0);
    step();
    check_val("pre_rst_regwrite", o_RegWrite, 1);
    drive(0, 1, 32'h2222_2222, 5'd0, 2'b00, 0, 32'h20, 32'h0);
    #3;
    reset = 1'b1;
    #1;
    check_val("async_rst_leds",     o_leds, 0);
    check_val("async_rst_regwrite", o_RegWrite, 0);
    check_val("async_rst_wdata",    o_WriteData, 0);
    step();
    reset = 1'b0;
    drive(1, 0, 32'h0, 5'd9, 2'b01, 1, 32'h20, 32'h0);
    #1;
    check_val("dropped_store", o_fwd_data, 32'h1111_1111);
    step();

`ifdef MEM_TIMER_EN
    begin
      logic seen_max;
      int   waited;
      seen_max = 1'b0;
      drive(0, 1, 32'hFFFF_FFFD, 5'd0, 2'b00, 0, 32'h4000_0000, 32'h0);
      step();
      drive(0, 1, 32'hFFFF_FFFD, 5'd0, 2'b00, 0, 32'h4000_0004, 32'h0);
      step();
      drive(0, 1, 32'h3, 5'd0, 2'b00, 0, 32'h4000_0008, 32'h0);
      step();
      check_val("tmr_irq_early", o_irq, 0);
      drive(1, 0, 32'h0, 5'd0, 2'b01, 0, 32'h4000_0004, 32'h0);
      waited = 0;
      while (waited < 20 && !o_irq) begin
        step();
        waited++;
        if (o_fwd_data == 32'hFFFF_FFFF) seen_max = 1'b1;
      end
      check_val("tmr_irq_rise",  o_irq, 1);
      check_val("tmr_wait_cyc",  waited, 3);
      check_val("tmr_hit_max",   seen_max, 1);
      check_val("tmr_reload",    o_fwd_data, 32'hFFFF_FFFD);
      drive(0, 1, 32'h3, 5'd0, 2'b00, 0, 32'h4000_0008, 32'h0);
      step();
      check_val("tmr_irq_clear", o_irq, 0);
      drive(1, 0, 32'h0, 5'd0, 2'b01, 0, 32'h4000_0008, 32'h0);
      #1;
      check_val("tmr_tcon_read", o_fwd_data, 3);
      step();
    end
`else
    drive(0, 1, 32'h3, 5'd0, 2'b00, 0, 32'h4000_0008, 32'h0);
    step();
    drive(0, 1, 32'hFFFF_FFFD, 5'd0, 2'b00, 0, 32'h4000_0000, 32'h0);
    step();
    drive(1, 0, 32'h0, 5'd0, 2'b01, 0, 32'h4000_0000, 32'h0);
    #1;
    check_val("notmr_th_read", o_fwd_data, 0);
    drive(1, 0, 32'h0, 5'd0, 2'b01, 0, 32'h4000_0008, 32'h0);
    #1;
    check_val("notmr_tcon_read", o_fwd_data, 0);
    repeat (5) step();
    check_val("notmr_irq", o_irq, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
